// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and rotating-priority pick helper for fifo_wr_arbiter
//   arb_state_e : S_IDLE (no grant) / S_LOCKED (one requester owns the push port)
//   rr_pick     : one-hot pick of the first set bit of req at or after ptr, wrapping modulo n
package fifo_arb_pkg;

  typedef enum logic {S_IDLE, S_LOCKED} arb_state_e;

  localparam int MAX_REQ = 32;
  localparam int IDX_W   = 5;

  // ptr is the index holding top priority (one past the last owner); lower k wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input logic [IDX_W:0]     n
  );
    logic [IDX_W:0] idx;
    rr_pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (idx >= n) idx = idx - n;
      if ((IDX_W + 1)'(k) < n && req[idx[IDX_W-1:0]]) rr_pick = MAX_REQ'(1) << idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker
//   req_i   : request vector
//   ptr_i   : index with top priority this round
//   grant_o : one-hot winner, 0 when no request
//   any_o   : at least one request present
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic                 any_o
);

  logic [MAX_REQ-1:0] pick;

  assign pick    = rr_pick(MAX_REQ'(req_i), IDX_W'(ptr_i), (IDX_W + 1)'(N));
  assign grant_o = pick[N-1:0];
  assign any_o   = |pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one sync_fifo push port between NUM_REQ producers
//   clk_i, rst_i             : clock, synchronous active-high reset
//   req_data_i/valid/last    : per-requester beat interface, req_ready_o is per-requester ready
//   fifo_full_i              : downstream full, gates every beat
//   fifo_push_o/fifo_data_o  : downstream write side
//   grant_o                  : one-hot owner (0 when idle), busy_o high while locked
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = $clog2(MAX_BURST) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e           state;
  logic [NUM_REQ-1:0]   pick;
  logic                 any;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        ptr;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic                 open;
  logic                 done;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i  (req_valid_i),
    .ptr_i  (ptr),
    .grant_o(pick),
    .any_o  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = IW'(i);
  end

  // The port is open to the owner only while locked, out of reset and not full.
  assign open        = state == S_LOCKED && !rst_i && !fifo_full_i;
  assign req_ready_o = open ? grant_o : '0;
  assign fifo_push_o = open && req_valid_i[gidx];
  assign fifo_data_o = state == S_LOCKED ? req_data_i[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign done        = req_last_i[gidx] || burst_cnt == CNT_WIDTH'(MAX_BURST - 1);
  assign busy_o      = state == S_LOCKED;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      grant_o   <= '0;
      gidx      <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (any) begin
        state   <= S_LOCKED;
        grant_o <= pick;
        gidx    <= pick_idx;
      end
    end else if (fifo_push_o) begin
      if (done) begin
        state     <= S_IDLE;
        grant_o   <= '0;
        burst_cnt <= '0;
        ptr       <= gidx == IW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter against a burst-level model
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            fifo_full_i = 1'b0;
  logic            fifo_push_o;
  logic [DW-1:0]   fifo_data_o;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_data_i (req_data_i),
    .req_valid_i(req_valid_i),
    .req_last_i (req_last_i),
    .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i),
    .fifo_push_o(fifo_push_o),
    .fifo_data_o(fifo_data_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_q[$];
  int            gseq[$];
  int            owner = -1;
  int            cnt = 0;
  int            last_owner = N - 1;
  int            seq[N];
  int            bcnt[N];
  int            blen[N];
  logic [N-1:0]  vmask = '0;
  logic [N-1:0]  prev_g = '0;
  int            vpct = 100;
  int            fpct = 0;
  int            push_seen = 0;
  bit            rand_len = 0;
  bit            running = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_of(input int i);
    return {i[7:0], seq[i][23:0]};
  endfunction

  // One cycle: drive inputs at negedge, compare control outputs against the model,
  // queue the expected beat, then advance producers and the model across the edge.
  task automatic step(input bit r, input bit ff);
    logic [N-1:0] v, l, eg, er;
    bit ep;
    int nxt;
    @(negedge clk);
    rst_i = r;
    for (int i = 0; i < N; i++) begin
      v[i] = vmask[i] && ($urandom_range(99) < vpct);
      l[i] = v[i] ? (bcnt[i] == blen[i] - 1) : 1'($urandom_range(1));
      req_data_i[i*DW +: DW] = beat_of(i);
    end
    req_valid_i = v;
    req_last_i  = l;
    fifo_full_i = ff || ($urandom_range(99) < fpct);
    #1;
    eg = '0;
    er = '0;
    ep = 0;
    if (owner >= 0) eg[owner] = 1'b1;
    if (!r && owner >= 0 && !fifo_full_i) begin
      er[owner] = 1'b1;
      ep = v[owner];
    end
    chk("grant", grant_o, eg);
    chk("ready", req_ready_o, er);
    chk("push", fifo_push_o, ep);
    chk("busy", busy_o, owner >= 0);
    if (owner < 0) chk("idle_data", fifo_data_o, 0);
    if (ep) exp_q.push_back(beat_of(owner));
    if (fifo_push_o) push_seen++;
    if (grant_o != 0 && grant_o != prev_g)
      for (int i = 0; i < N; i++) if (grant_o[i]) gseq.push_back(i);
    prev_g = grant_o;
    for (int i = 0; i < N; i++) begin
      if (v[i] && er[i]) begin
        seq[i]++;
        if (l[i]) begin
          bcnt[i] = 0;
          if (rand_len) blen[i] = $urandom_range(1, 20);
        end else begin
          bcnt[i]++;
        end
      end
    end
    if (r) begin
      owner = -1;
      cnt = 0;
      last_owner = N - 1;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        nxt = (last_owner + k) % N;
        if (v[nxt] && owner < 0) owner = nxt;
      end
      cnt = 0;
    end else if (ep) begin
      cnt++;
      if (l[owner] || cnt == MB) begin
        last_owner = owner;
        owner = -1;
        cnt = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (running) begin
        if (fifo_push_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL data unexpected push actual=%0h required=none at %0t", fifo_data_o, $time);
          end else begin
            chk("data", fifo_data_o, exp_q.pop_front());
          end
        end else if (exp_q.size() != 0) begin
          checks++;
          failures++;
          $display("FAIL data missing push actual=none required=%0h at %0t", exp_q[0], $time);
          exp_q.delete();
        end
      end
    end
  end

  initial begin
    int order2[5] = '{0, 1, 2, 3, 0};
    int order3[5] = '{1, 2, 1, 2, 1};
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      bcnt[i] = 0;
      blen[i] = 4;
    end
    running = 1;
    step(1, 0);
    step(1, 0);
    vmask = 4'b0001;
    blen[0] = 3;
    push_seen = 0;
    repeat (5) step(0, 0);
    chk("single_burst_pushes", push_seen, 3);
    vmask = '0;
    step(1, 0);
    for (int i = 0; i < N; i++) begin
      blen[i] = 2;
      bcnt[i] = 0;
    end
    vmask = '1;
    gseq.delete();
    repeat (16) step(0, 0);
    for (int k = 0; k < 5; k++) chk("rr_order", gseq.size() > k ? gseq[k] : -1, order2[k]);
    vmask = '0;
    step(1, 0);
    vmask = 4'b0110;
    blen[1] = 40;
    bcnt[1] = 0;
    blen[2] = 1000;
    bcnt[2] = 0;
    gseq.delete();
    repeat (80) step(0, 0);
    for (int k = 0; k < 5; k++) chk("max_burst_order", gseq.size() > k ? gseq[k] : -1, order3[k]);
    vmask = 4'b0100;
    step(1, 0);
    repeat (3) step(0, 0);
    repeat (5) step(0, 1);
    repeat (10) step(0, 0);
    repeat (4) step(0, 0);
    vmask = 4'b0101;
    step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("post_reset_grant", grant_o, 4'b0001);
    step(1, 0);
    vmask = '1;
    vpct = 70;
    fpct = 20;
    rand_len = 1;
    for (int i = 0; i < N; i++) begin
      blen[i] = $urandom_range(1, 20);
      bcnt[i] = 0;
    end
    repeat (10000) step($urandom_range(999) == 0, 0);
    vmask = '0;
    repeat (2) step(0, 0);
    #5;
    running = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
